// File: rtl/conv_window_fetch_ctrl_if.sv
// SRAM read port and window handshake shared by the fetch controller and its neighbours.
// master = controller side, slave = SRAM model / window register side.
interface conv_window_fetch_ctrl_if #(
  parameter int ADDR_W = 16
);
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [7:0]        rd_data;
  logic [8:0][7:0]   win_data;
  logic              win_valid;
  logic              win_ready;
  logic              stall;

  modport master (
    output rd_en, rd_addr, win_data, win_valid, stall,
    input  rd_data, win_ready
  );

  modport slave (
    input  rd_en, rd_addr, win_data, win_valid, stall,
    output rd_data, win_ready
  );
endinterface

// File: rtl/conv_window_fetch_ctrl.sv
// Walks a 3x3, stride-1, unpadded window over an 8-bit feature map in SRAM and
// hands each assembled window to the DLA window register via valid/ready.
module conv_window_fetch_ctrl #(
  parameter int ADDR_W = 16,
  parameter int DIM_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [DIM_W-1:0]  ifm_width,
  input  logic [DIM_W-1:0]  ifm_height,
  output logic              busy,
  output logic              done,
  conv_window_fetch_ctrl_if.master bus
);

  typedef enum logic [2:0] {IDLE, FETCH, CAPT, VALID, DONE} state_t;

  state_t            state;
  logic [ADDR_W-1:0] base_q;
  logic [DIM_W-1:0]  w_q, h_q, row, col;
  logic [1:0]        kx, ky, nxt_kx, nxt_ky;
  logic [3:0]        k, cap_k;
  logic              cap_en;
  logic              rd_en_q, win_valid_q;
  logic [ADDR_W-1:0] rd_addr_q;
  logic [8:0][7:0]   win_data_q;
  logic              col_more, row_more;

  // Pixel address of (r+oy, c+ox); products are 2*DIM_W wide, sum wraps at ADDR_W.
  function automatic logic [ADDR_W-1:0] win_addr(
    input logic [ADDR_W-1:0] b,
    input logic [DIM_W-1:0]  w,
    input logic [DIM_W-1:0]  r,
    input logic [DIM_W-1:0]  c,
    input logic [1:0]        oy,
    input logic [1:0]        ox
  );
    logic [2*DIM_W-1:0] y, x, off;
    y   = {{DIM_W{1'b0}}, r} + {{(2*DIM_W-2){1'b0}}, oy};
    x   = {{DIM_W{1'b0}}, c} + {{(2*DIM_W-2){1'b0}}, ox};
    off = y * {{DIM_W{1'b0}}, w} + x;
    return b + ADDR_W'(off);
  endfunction

  // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    nxt_kx = kx + 2'd1;
    nxt_ky = ky;
    if (kx == 2'd2) begin
      nxt_kx = 2'd0;
      nxt_ky = ky + 2'd1;
    end
    col_more = col < (w_q - DIM_W'(3));
    row_more = row < (h_q - DIM_W'(3));
  end

  // NOTE: state is updated with non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= IDLE;
      base_q      <= '0;
      w_q         <= '0;
      h_q         <= '0;
      row         <= '0;
      col         <= '0;
      kx          <= '0;
      ky          <= '0;
      k           <= '0;
      cap_k       <= '0;
      cap_en      <= 1'b0;
      rd_en_q     <= 1'b0;
      rd_addr_q   <= '0;
      win_valid_q <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      // NOTE: the window byte array is reset on purpose; consumers expect zeros after reset.
      win_data_q  <= '0;
    end else begin
      // Read data returns one cycle after the strobe, so capture trails the read by one cycle.
      cap_en <= rd_en_q;
      cap_k  <= k;
      if (cap_en) win_data_q[cap_k] <= bus.rd_data;

      case (state)
        IDLE: begin
          if (start) begin
            base_q <= base_addr;
            w_q    <= ifm_width;
            h_q    <= ifm_height;
            busy   <= 1'b1;
            if (ifm_width < DIM_W'(3) || ifm_height < DIM_W'(3)) begin
              state <= DONE;
            end else begin
              row       <= '0;
              col       <= '0;
              kx        <= '0;
              ky        <= '0;
              k         <= '0;
              rd_en_q   <= 1'b1;
              rd_addr_q <= base_addr;
              state     <= FETCH;
            end
          end
        end

        FETCH: begin
          if (k == 4'd8) begin
            rd_en_q <= 1'b0;
            state   <= CAPT;
          end else begin
            k         <= k + 4'd1;
            kx        <= nxt_kx;
            ky        <= nxt_ky;
            rd_addr_q <= win_addr(base_q, w_q, row, col, nxt_ky, nxt_kx);
          end
        end

        CAPT: begin
          win_valid_q <= 1'b1;
          state       <= VALID;
        end

        VALID: begin
          if (bus.win_ready) begin
            win_valid_q <= 1'b0;
            kx          <= '0;
            ky          <= '0;
            k           <= '0;
            if (col_more) begin
              col       <= col + DIM_W'(1);
              rd_en_q   <= 1'b1;
              rd_addr_q <= win_addr(base_q, w_q, row, col + DIM_W'(1), 2'd0, 2'd0);
              state     <= FETCH;
            end else if (row_more) begin
              col       <= '0;
              row       <= row + DIM_W'(1);
              rd_en_q   <= 1'b1;
              rd_addr_q <= win_addr(base_q, w_q, row + DIM_W'(1), '0, 2'd0, 2'd0);
              state     <= FETCH;
            end else begin
              done  <= 1'b1;
              state <= DONE;
            end
          end
        end

        DONE: begin
          // A degenerate job arrives with done low and spends one extra cycle here.
          if (done) begin
            done  <= 1'b0;
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            done <= 1'b1;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

  assign bus.rd_en     = rd_en_q;
  assign bus.rd_addr   = rd_addr_q;
  assign bus.win_data  = win_data_q;
  assign bus.win_valid = win_valid_q;
  assign bus.stall     = win_valid_q & ~bus.win_ready;

endmodule

// File: doc/conv_window_fetch_ctrl.md
Name: conv_window_fetch_ctrl

Overview:
Sequencer that walks a 3x3 convolution window across an 8-bit input feature map in local SRAM. It issues byte reads, assembles the nine window bytes, and presents them to the DLA window register stage through a valid/ready handshake. It also drives that stage's stall input. Stride is 1 and there is no padding; the block produces (W-2)*(H-2) windows per job in raster order.

Parameters:
ADDR_W, 16, SRAM byte-address width
DIM_W, 8, width of the map dimension fields

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-low
start  in  1  job start pulse; sampled only in IDLE
base_addr  in  ADDR_W  address of map pixel (0,0)
ifm_width  in  DIM_W  map width W in pixels
ifm_height  in  DIM_W  map height H in pixels
rd_en  out  1  SRAM read strobe
rd_addr  out  ADDR_W  SRAM read address
rd_data  in  8  SRAM read data, valid exactly 1 cycle after rd_en
win_data  out  8 x [8:0]  window bytes, index k = ky*3+kx
win_valid  out  1  window bytes valid
win_ready  in  1  consumer accepts window
stall  out  1  win_valid & ~win_ready, for the downstream window register
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse at job end

Behaviour:
- Reset (rst=0 at a clock edge) forces IDLE from any state, including mid-job. All outputs go to 0 and all win_data bytes to 8'h00. The row/col/k counters clear.
- States: IDLE, FETCH, CAPT, VALID, DONE.
- IDLE: start=1 latches base_addr, W and H.
  - If W<3 or H<3, go to DONE. No reads are issued and no window is produced.
  - Otherwise clear row=0, col=0, k=0 and go to FETCH.
- FETCH: rd_en=1 for exactly 9 consecutive cycles, k=0..8.
  - rd_addr = base + (row + k/3)*W + (col + k%3), truncated to ADDR_W (wraps modulo 2^ADDR_W).
  - Data for read k is captured into win_data[k] on the edge one cycle after that read is issued.
  - After k=8 is issued, go to CAPT.
- CAPT: rd_en=0 for one cycle; win_data[8] is captured. Go to VALID.
- VALID: win_valid=1; win_data is held stable and rd_en=0.
  - On win_ready=1 the window is transferred at that edge.
  - If col < W-3: col++, k=0, go to FETCH.
  - Else if row < H-3: col=0, row++, k=0, go to FETCH.
  - Else go to DONE.
- DONE: done=1 for one cycle, then go to IDLE. busy is still 1 in DONE.
- Latency: with start high in cycle 0, reads are issued in cycles 1-9 and win_valid first goes high in cycle 11. Each later window appears 11 cycles after the previous handshake cycle if win_ready is high on arrival.
- win_valid never drops without a handshake. win_ready while win_valid=0 is ignored.
- start while busy=1 is ignored; a start in the cycle done is asserted is also ignored.
- win_data retains the last window after the job completes, until the next FETCH overwrites it or a reset clears it.
- Address arithmetic: the products use DIM_W+DIM_W bits, and the sum is truncated to ADDR_W.

Test Plan:
1. W=3, H=3, base=0x0100, SRAM[a]=a[7:0], win_ready=1. Required: rd_addr sequence 0x100,101,102,103,104,105,106,107,108; one window with win_data[k]=k; done pulses once; busy falls.
2. W=4, H=3, base=0. Required: two windows. The first window's addresses are 0,1,2,4,5,6,8,9,10; the second window's are 1,2,3,5,6,7,9,10,11; done follows the second handshake.
3. Backpressure: case 1 with win_ready=0 for 5 cycles after win_valid rises. Required: win_valid=1, stall=1 and win_data stable for those 5 cycles; rd_en=0 throughout; a single handshake, then done.
4. Degenerate: W=2, H=5, start. Required: no rd_en ever, win_valid never high, done pulses 2 cycles after the start cycle.
5. Reset mid-job: W=5, H=5, rst=0 during the 4th FETCH cycle. Required: the next cycle shows IDLE with all outputs 0 and win_data all 0x00; a new start with W=3, H=3 behaves exactly as in scenario 1.
6. start pulsed during VALID of a W=4, H=4 job. Required: it is ignored; exactly 4 windows in raster order (col,row) = (0,0),(1,0),(0,1),(1,1), then one done.
